// File: rtl/multdiv_seq.sv
// Sequential signed multiply/divide: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, one iteration per clock, sign and exception fixed up at the end.
module multdiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [2*W-1:0] LIM = (2*W)'(1) << (W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_mult;
  logic            neg;
  logic            b_zero;
  logic [W-1:0]    opb;
  logic [2*W-1:0]  acc;

  logic            start_c;
  logic [W-1:0]    mag_a_c;
  logic [W-1:0]    mag_b_c;
  logic [W:0]      sum_c;
  logic [W-1:0]    shifted_c;
  logic [W-1:0]    diff_c;
  logic [2*W-1:0]  acc_nxt_c;
  logic [2*W-1:0]  val_c;
  logic [2*W-1:0]  sval_c;
  logic [W-1:0]    res_c;
  logic            exc_c;

  assign start_c = ctrl_MULT | ctrl_DIV;
  assign mag_a_c = data_operandA[W-1] ? W'(-data_operandA) : data_operandA;
  assign mag_b_c = data_operandB[W-1] ? W'(-data_operandB) : data_operandB;

  // One iteration step plus the signed result/exception it would produce if it were the last.
  // acc holds {partial product | remainder, multiplier | dividend->quotient}.
  always_comb begin
    sum_c     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : (W+1)'(0));
    shifted_c = {acc[2*W-2:W], acc[W-1]};
    diff_c    = shifted_c - opb;
    if (is_mult)
      acc_nxt_c = {sum_c, acc[W-1:1]};
    else if (shifted_c >= opb)
      acc_nxt_c = {diff_c, acc[W-2:0], 1'b1};
    else
      acc_nxt_c = {shifted_c, acc[W-2:0], 1'b0};

    val_c  = is_mult ? acc_nxt_c : {{W{1'b0}}, acc_nxt_c[W-1:0]};
    sval_c = neg ? (2*W)'(-val_c) : val_c;
    res_c  = sval_c[W-1:0];
    // Negative results may reach -2^(W-1); positive ones stop at 2^(W-1)-1.
    exc_c  = neg ? (val_c > LIM) : (val_c >= LIM);
    if (!is_mult && b_zero) begin
      res_c = '0;
      exc_c = 1'b1;
    end
  end

  // Control FSM and registered outputs; flush beats start, start beats iteration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      is_mult        <= 1'b0;
      neg            <= 1'b0;
      b_zero         <= 1'b0;
      opb            <= '0;
      acc            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else if (start_c) begin
        state   <= RUN;
        busy    <= 1'b1;
        cnt     <= '0;
        is_mult <= ctrl_MULT;
        neg     <= data_operandA[W-1] ^ data_operandB[W-1];
        b_zero  <= (data_operandB == '0);
        opb     <= mag_b_c;
        acc     <= {{W{1'b0}}, mag_a_c};
      end else begin
        case (state)
          RUN: begin
            acc <= acc_nxt_c;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(W - 1)) begin
              state          <= DONE;
              busy           <= 1'b0;
              data_result    <= res_c;
              data_exception <= exc_c;
              data_resultRDY <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: 32-bit and 8-bit instances, checking results,
// exceptions, latency, flush/restart/back-to-back behaviour and asynchronous reset.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        m32 = 1'b0, d32 = 1'b0, f32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [31:0] res32;
  logic        exc32, rdy32, busy32;

  logic        m8 = 1'b0, d8 = 1'b0, f8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  res8;
  logic        exc8, rdy8, busy8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  multdiv_seq #(.WIDTH(32)) u_dut32 (
    .clock(clock), .reset(reset), .ctrl_MULT(m32), .ctrl_DIV(d32), .flush(f32),
    .data_operandA(a32), .data_operandB(b32), .data_result(res32),
    .data_exception(exc32), .data_resultRDY(rdy32), .busy(busy32)
  );

  multdiv_seq #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .ctrl_MULT(m8), .ctrl_DIV(d8), .flush(f8),
    .data_operandA(a8), .data_operandB(b8), .data_result(res8),
    .data_exception(exc8), .data_resultRDY(rdy8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge right after a start was driven; returns edges until RDY.
  task automatic wait_rdy32(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        m32 = 1'b0; d32 = 1'b0;
        a32 = $urandom; b32 = $urandom;
      end
      if (busy32) busy_n++;
    end while (!rdy32 && lat < 100);
  endtask

  task automatic wait_rdy8(output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        m8 = 1'b0; d8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
    end while (!rdy8 && lat < 100);
  endtask

  task automatic op32(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic ee, input string tag);
    int lat, bn;
    m32 = m; d32 = d; a32 = a; b32 = b;
    wait_rdy32(lat, bn);
    check({tag, "_lat"}, 64'(lat), 64'd33);
    check({tag, "_busy"}, 64'(bn), 64'd32);
    check({tag, "_res"}, 64'(res32), 64'(er));
    check({tag, "_exc"}, 64'(exc32), 64'(ee));
    @(negedge clock);
    check({tag, "_pulse"}, 64'(rdy32), 64'd0);
  endtask

  initial begin
    int lat, bn, seen;

    repeat (3) @(negedge clock);
    check("rst_res32", 64'(res32), 64'd0);
    check("rst_exc32", 64'(exc32), 64'd0);
    check("rst_rdy32", 64'(rdy32), 64'd0);
    check("rst_busy32", 64'(busy32), 64'd0);
    reset = 1'b0;

    // Directed arithmetic vectors
    op32(1'b1, 1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7x-3");
    op32(1'b1, 1'b0, 32'h4000_0000, 32'd4,         32'h0000_0000, 1'b1, "mul_ovf");
    op32(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div_-7/2");
    op32(1'b0, 1'b1, 32'd5,         32'd0,         32'h0000_0000, 1'b1, "div_by0");
    op32(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_min/-1");
    op32(1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30,        1'b0, "mul_-5x-6");
    op32(1'b0, 1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, "div_100/-7");
    op32(1'b1, 1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, "mul_min_x1");
    op32(1'b1, 1'b1, 32'd6,         32'd7,         32'd42,        1'b0, "both_is_mul");

    // Flush mid-operation
    m32 = 1'b1; a32 = 32'd3; b32 = 32'd3;
    @(negedge clock);
    m32 = 1'b0;
    repeat (9) @(negedge clock);
    f32 = 1'b1;
    @(negedge clock);
    f32 = 1'b0;
    check("flush_busy", 64'(busy32), 64'd0);
    check("flush_keep_res", 64'(res32), 64'd42);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (rdy32) seen++;
    end
    check("flush_no_rdy", 64'(seen), 64'd0);
    op32(1'b0, 1'b1, 32'd9, 32'd3, 32'd3, 1'b0, "div_9/3");

    // Restart during RUN: only the second operation may report
    m32 = 1'b1; a32 = 32'd3; b32 = 32'd3;
    @(negedge clock);
    m32 = 1'b0;
    repeat (19) @(negedge clock);
    op32(1'b1, 1'b0, 32'd5, 32'd5, 32'd25, 1'b0, "restart_5x5");

    // Back-to-back: new start in the DONE cycle
    m32 = 1'b1; a32 = 32'd2; b32 = 32'd3;
    wait_rdy32(lat, bn);
    check("b2b_first_res", 64'(res32), 64'd6);
    m32 = 1'b1; a32 = 32'd4; b32 = 32'd5;
    wait_rdy32(lat, bn);
    check("b2b_lat", 64'(lat), 64'd33);
    check("b2b_res", 64'(res32), 64'd20);

    // 8-bit instance
    m8 = 1'b1; a8 = 8'd127; b8 = 8'd2;
    wait_rdy8(lat);
    check("w8_lat", 64'(lat), 64'd9);
    check("w8_res", 64'(res8), 64'hFE);
    check("w8_exc", 64'(exc8), 64'd1);

    // Asynchronous reset mid-RUN
    m8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
    m32 = 1'b1; a32 = 32'd3; b32 = 32'd5;
    @(negedge clock);
    m8 = 1'b0; m32 = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_res8", 64'(res8), 64'd0);
    check("arst_exc8", 64'(exc8), 64'd0);
    check("arst_busy8", 64'(busy8), 64'd0);
    check("arst_rdy8", 64'(rdy8), 64'd0);
    check("arst_res32", 64'(res32), 64'd0);
    check("arst_busy32", 64'(busy32), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (rdy8 || rdy32) seen++;
    end
    check("arst_no_rdy", 64'(seen), 64'd0);

    // 8-bit divide right after idle period
    d8 = 1'b1; a8 = 8'hF6; b8 = 8'd3;
    wait_rdy8(lat);
    check("w8_div_lat", 64'(lat), 64'd9);
    check("w8_div_res", 64'(res8), 64'hFD);
    check("w8_div_exc", 64'(exc8), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
